// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment scanner:
// segment bit order, hex glyph table and scan state encoding.
package seg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_W = SEG_G + 1;

  // Active-high glyphs, bit SEG_G down to SEG_A; entry 15 first.
  localparam logic [15:0][SEG_W-1:0] HEX_PAT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Nibble to active-high 7-segment glyph; pin polarity is applied by the parent.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] pattern
);

  assign pattern = HEX_PAT[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with frame-synchronous updates.
// Optional leading-zero blanking is built when SEG_LZB_EN is defined.
//
// state    | meaning
// ST_BLANK | dead time at slot start, all digit enables and segments off
// ST_SHOW  | current digit enabled, segments/dp show its nibble
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int PRESCALE        = 4096,
  parameter int BLANK_CYCLES    = 64,
  parameter bit SEG_ACTIVE_LOW  = 1'b1,
  parameter bit DIG_ACTIVE_HIGH = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [4*DIGITS-1:0]   upd_data_i,
  input  logic [DIGITS-1:0]     upd_dots_i,
  input  logic [DIGITS-1:0]     upd_blank_i,
  input  logic                  upd_valid_i,
  output logic                  upd_ready_o,
  output logic [SEG_W-1:0]      seg_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     dig_o,
  output logic                  frame_o
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(PRESCALE);
  localparam logic [IDX_W-1:0] IDX_TOP    = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam scan_state_t SLOT_ENTRY = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;
  localparam logic [SEG_W-1:0]  SEG_OFF = SEG_ACTIVE_LOW ? '1 : '0;
  localparam logic              DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] DIG_OFF = DIG_ACTIVE_HIGH ? '0 : '1;

  logic [4*DIGITS-1:0] shadow_data, disp_data, data_cur;
  logic [DIGITS-1:0]   shadow_dots, disp_dots, dots_cur;
  logic [DIGITS-1:0]   shadow_blank, disp_blank, blank_cur;
  logic                pending;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  scan_state_t         state;

  logic                frame_start, commit;
  logic [3:0]          cur_nib;
  logic                cur_dot, cur_blank, lz_dark, dark;
  logic [SEG_W-1:0]    hex_pat;
  logic [DIGITS-1:0]   dig_onehot;

  assign frame_start = (cnt == '0) && (idx == IDX_TOP);
  assign commit      = frame_start && pending;
  assign upd_ready_o = !pending;

  // Look through the commit so a zero-dead-time build never shows stale data
  // in the first cycle of a new frame.
  assign data_cur  = commit ? shadow_data  : disp_data;
  assign dots_cur  = commit ? shadow_dots  : disp_dots;
  assign blank_cur = commit ? shadow_blank : disp_blank;

  always_comb begin
    cur_nib   = 4'h0;
    cur_dot   = 1'b0;
    cur_blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (IDX_W'(k) == idx) begin
        cur_nib   = data_cur[4*k +: 4];
        cur_dot   = dots_cur[k];
        cur_blank = blank_cur[k];
      end
    end
  end

`ifdef SEG_LZB_EN
  logic zero_run;
  always_comb begin
    zero_run = 1'b1;
    lz_dark  = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (data_cur[4*k +: 4] == 4'h0);
      if (IDX_W'(k) == idx) lz_dark = zero_run && (k != 0);
    end
  end
`else
  assign lz_dark = 1'b0;
`endif

  assign dark       = cur_blank || lz_dark;
  assign dig_onehot = DIGITS'(1) << idx;

  seg_hex_decode u_hex_decode (
    .nibble  (cur_nib),
    .pattern (hex_pat)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shadow_data  <= '0;
      shadow_dots  <= '0;
      shadow_blank <= '0;
      disp_data    <= '0;
      disp_dots    <= '0;
      disp_blank   <= '0;
      pending      <= 1'b0;
      cnt          <= '0;
      idx          <= IDX_TOP;
      state        <= SLOT_ENTRY;
      frame_o      <= 1'b0;
      dig_o        <= DIG_OFF;
      seg_o        <= SEG_OFF;
      dp_o         <= DP_OFF;
    end else begin
      if (upd_valid_i && !pending) begin
        shadow_data  <= upd_data_i;
        shadow_dots  <= upd_dots_i;
        shadow_blank <= upd_blank_i;
        pending      <= 1'b1;
      end else if (commit) begin
        disp_data  <= shadow_data;
        disp_dots  <= shadow_dots;
        disp_blank <= shadow_blank;
        pending    <= 1'b0;
      end

      frame_o <= frame_start;

      if (cnt == CNT_LAST) begin
        cnt   <= '0;
        idx   <= (idx == '0) ? IDX_TOP : idx - 1'b1;
        state <= SLOT_ENTRY;
      end else begin
        cnt <= cnt + 1'b1;
        if (state == ST_BLANK && cnt == BLANK_LAST) state <= ST_SHOW;
      end

      if (state == ST_SHOW) begin
        dig_o <= DIG_ACTIVE_HIGH ? dig_onehot : ~dig_onehot;
        seg_o <= dark ? SEG_OFF : (SEG_ACTIVE_LOW ? ~hex_pat : hex_pat);
        dp_o  <= (cur_dot && !cur_blank) ? ~DP_OFF : DP_OFF;
      end else begin
        dig_o <= DIG_OFF;
        seg_o <= SEG_OFF;
        dp_o  <= DP_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a cycle-level reference model queues the
// expected glyph of every digit slot, a monitor pops one entry per lit run.
module tb_seg_scan_ctrl;

  localparam int FRAME = 64;
  localparam int SHOW_LEN = 14;
  localparam int DARK_LEN = 2;
  localparam logic [6:0] HEX_TB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    logic [3:0] dig;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic        clk, rst_n;
  logic [15:0] upd_data;
  logic [3:0]  upd_dots, upd_blank;
  logic        upd_valid, upd_ready_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  dig_o;
  logic        frame_o;

  int total = 0;
  int bad = 0;

  seg_scan_ctrl #(
    .DIGITS(4), .PRESCALE(16), .BLANK_CYCLES(2),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_HIGH(1'b1)
  ) dut (
    .CLK(clk), .RST_N(rst_n),
    .upd_data_i(upd_data), .upd_dots_i(upd_dots), .upd_blank_i(upd_blank),
    .upd_valid_i(upd_valid), .upd_ready_o(upd_ready_o),
    .seg_o(seg_o), .dp_o(dp_o), .dig_o(dig_o), .frame_o(frame_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  int          m_c;
  bit          m_pend, m_frame;
  logic [15:0] m_sh_data, m_disp;
  logic [3:0]  m_sh_dots, m_sh_blank, m_dots, m_blank;
  exp_t        exp_q[$];

  function automatic exp_t make_exp(int k);
    exp_t e;
    logic [15:0] up;
    bit dark;
    up = m_disp >> (4 * k);
    dark = m_blank[k];
`ifdef SEG_LZB_EN
    if (k > 0 && up == 16'h0) dark = 1'b1;
`endif
    e.dig = 4'(1 << k);
    e.seg = dark ? 7'h7F : ~HEX_TB[up[3:0]];
    e.dp  = (m_dots[k] && !m_blank[k]) ? 1'b0 : 1'b1;
    return e;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_c = 0; m_pend = 0; m_frame = 0;
      m_sh_data = '0; m_sh_dots = '0; m_sh_blank = '0;
      m_disp = '0; m_dots = '0; m_blank = '0;
      exp_q.delete();
    end else begin
      bit pend_before;
      pend_before = m_pend;
      m_frame = (m_c % FRAME == 0);
      if (m_frame && m_pend) begin
        m_disp = m_sh_data; m_dots = m_sh_dots; m_blank = m_sh_blank;
        m_pend = 0;
      end
      if (upd_valid && !pend_before) begin
        m_sh_data = upd_data; m_sh_dots = upd_dots; m_sh_blank = upd_blank;
        m_pend = 1;
      end
      if (m_frame)
        for (int k = 3; k >= 0; k--) exp_q.push_back(make_exp(k));
      m_c++;
    end
  end

  // Monitor
  bit   in_run = 0;
  int   run_len = 0, dark_len = 0;
  exp_t cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_run = 0; run_len = 0; dark_len = 0;
    end else begin
      chk("frame_o", frame_o, m_frame);
      chk("upd_ready", upd_ready_o, !m_pend);
      if (dig_o != 4'b0000) begin
        if (!in_run) begin
          chk("dark_len", dark_len, DARK_LEN);
          if (exp_q.size() == 0) begin
            chk("queue_empty", 1, 0);
            cur.dig = 4'h0; cur.seg = 7'h0; cur.dp = 1'b0;
          end else cur = exp_q.pop_front();
          in_run = 1; run_len = 0;
        end
        run_len++;
        chk("dig_o", dig_o, cur.dig);
        chk("seg_o", seg_o, cur.seg);
        chk("dp_o", dp_o, cur.dp);
      end else begin
        if (in_run) begin
          chk("show_len", run_len, SHOW_LEN);
          in_run = 0; dark_len = 0;
        end
        dark_len++;
        chk("dark_seg", seg_o, 7'h7F);
        chk("dark_dp", dp_o, 1'b1);
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic [3:0] dt, input logic [3:0] bl);
    int n;
    @(negedge clk);
    upd_data = d; upd_dots = dt; upd_blank = bl; upd_valid = 1'b1;
    n = 0;
    while (!upd_ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", n < 300, 1);
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_dig"}, dig_o, 4'b0000);
    chk({tag, "_seg"}, seg_o, 7'h7F);
    chk({tag, "_dp"}, dp_o, 1'b1);
    chk({tag, "_ready"}, upd_ready_o, 1'b1);
    chk({tag, "_frame"}, frame_o, 1'b0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; upd_valid = 1'b0;
    upd_data = '0; upd_dots = '0; upd_blank = '0;
    repeat (3) @(negedge clk);
    reset_checks("rst");
    #2 rst_n = 1'b1;
    repeat (80) @(negedge clk);

    // update plus back-pressure while it is pending
    send(16'h1234, 4'b0000, 4'b0000);
    repeat (5) @(negedge clk);
    send(16'hBEEF, 4'b0000, 4'b0000);
    repeat (140) @(negedge clk);

    // blank and dot masks
    send(16'h9876, 4'b0001, 4'b0010);
    repeat (140) @(negedge clk);

    // leading-zero patterns
    send(16'h0050, 4'b0000, 4'b0000);
    repeat (140) @(negedge clk);
    send(16'h0000, 4'b0100, 4'b0000);
    repeat (140) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 70)) @(negedge clk);
      send(16'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    repeat (140) @(negedge clk);

    // reset during digit 1 with an update pending
    n = 0;
    while (!frame_o && n < 100) begin @(negedge clk); n++; end
    chk("wait_frame", n < 100, 1);
    send(16'hA5C3, 4'b1010, 4'b0000);
    n = 0;
    while (dig_o != 4'b0010 && n < 100) begin @(negedge clk); n++; end
    chk("wait_dig1", n < 100, 1);
    chk("pending_before_rst", upd_ready_o, 1'b0);
    #2 rst_n = 1'b0;
    #1 reset_checks("midrst");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (140) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised multiplexed 7-segment display controller for the BX board's common-digit LED displays. Holds a DIGITS-wide hex value, scans one digit per time slot with a programmable dwell and a dead-time (anti-ghosting) gap, and drives segment, decimal-point and digit-enable pins. New values enter through a valid/ready port and are committed only at frame boundaries, so a frame never shows a mix of old and new digits. Sits between application logic and the top-level pin assignments.

## Interface
- DIGITS, 4: number of digits, 1..16.
- PRESCALE, 4096: CLK cycles per digit slot, ≥2.
- BLANK_CYCLES, 64: all-digits-off cycles at the start of each slot, 0 ≤ BLANK_CYCLES < PRESCALE.
- SEG_ACTIVE_LOW, 1: segment and dp pins are active-low when 1.
- DIG_ACTIVE_HIGH, 1: digit enables are active-high when 1.
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- upd_data_i  in  4*DIGITS  nibble k, bits [4k+3:4k], is digit k; digit 0 is the rightmost digit.
- upd_dots_i  in  DIGITS  decimal-point request per digit.
- upd_blank_i  in  DIGITS  force digit k dark (segments and dp).
- upd_valid_i  in  1  update offered.
- upd_ready_o  out  1  update slot free.
- seg_o  out  7  segments a..g on bits 0..6.
- dp_o  out  1  decimal point.
- dig_o  out  DIGITS  digit enables.
- frame_o  out  1  one-cycle pulse at each frame start.

## Operation
- Registers: shadow (data/dots/blank + pending flag), display copy, slot counter ($clog2(PRESCALE) bits), scan index ($clog2(DIGITS), min 1 bit), state.
- Handshake: transfer when upd_valid_i && upd_ready_o; upd_ready_o = !pending. The transfer loads the shadow and sets pending. While pending, valid is ignored and the source holds its data.
- Commit: on the frame-start edge, if pending, shadow→display and pending clears. upd_ready_o rises the cycle after. A transfer cannot coincide with a commit because ready is low whenever pending is set.
- Scan order: index DIGITS-1 down to 0, then wraps to DIGITS-1. Frame start is the first cycle of the slot for index DIGITS-1.
- States:
  - BLANK: counter < BLANK_CYCLES; dig_o all inactive; seg_o/dp_o off.
  - SHOW: rest of the slot; dig_o one-hot on the current index; seg_o = hex pattern of the nibble; dp_o = dots bit.
  - With BLANK_CYCLES=0, BLANK is never entered.
  - At counter = PRESCALE-1: counter clears, index advances, state goes to BLANK (or SHOW if BLANK_CYCLES=0).
- Hex patterns a..g, active-high, bits g..a:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Pins are inverted when SEG_ACTIVE_LOW.
- A blanked digit drives segments and dp off, but its enable still follows the scan so slot timing is unchanged.

## Timing
- All outputs are registered, with one cycle from state/index change to pin change.
- Reset values: dig_o all inactive; seg_o and dp_o off (7'h7F / 1 when active-low); frame_o 0; upd_ready_o 1; display copy and shadow 0; pending 0; index DIGITS-1; counter 0.
- Reset is async assert and sync deassert. Assertion mid-slot darkens the pins immediately and discards any pending update.
- Pin sequence, counting edge 0 as the first rising edge with RST_N high:
  - frame_o high after edge 0.
  - Pins dark for BLANK_CYCLES cycles.
  - dig_o[DIGITS-1] active for PRESCALE-BLANK_CYCLES cycles.
- Frame period DIGITS*PRESCALE cycles. Update latency: up to one frame plus one cycle from transfer to first display.

## Configuration
- SEG_LZB_EN defined: leading-zero blanking. Digit k>0 is dark when nibbles k..DIGITS-1 are all zero; its dp still follows upd_dots_i. Digit 0 is never blanked this way.
- SEG_LZB_EN undefined: every digit shows its nibble, zeros included.

## Structure
- Package seg_pkg holds:
  - the 16-entry hex pattern constant;
  - the segment bit order;
  - the BLANK/SHOW state enum.
- One combinational sub-module, seg_hex_decode: nibble in, 7-bit active-high pattern out. Polarity is applied in the parent.

## Test plan
Bench parameters: DIGITS=4, PRESCALE=16, BLANK_CYCLES=2, defaults elsewhere.
- Reset: hold RST_N low → dig_o=0000, seg_o=7F, dp_o=1, upd_ready_o=1. Release → frame_o pulses, 2 dark cycles, then dig_o=1000 for 14 cycles with seg_o=40 (digit '0').
- Update: transfer 16'h1234 mid-frame → upd_ready_o=0 and display unchanged until the next frame_o. Then digit 3 shows seg_o=79 ('1') and digit 0 shows 19 ('4'); upd_ready_o=1 the cycle after frame_o.
- Back-pressure: offer 16'hBEEF while 16'h1234 is pending → not accepted. Hold valid → accepted the cycle ready rises; shown one frame later.
- Masks: blank=0010, dots=0001 → digit 1 slot gives seg_o=7F, dp_o=1 with dig_o=0010 active; digit 0 gives dp_o=0.
- SEG_LZB_EN:
  - 16'h0050 → digits 3 and 2 dark, digit 1 '5' (12), digit 0 '0' (40).
  - 16'h0000 → only digit 0 lit.
  - Macro undefined → all four digits lit.
- Reset mid-operation: drop RST_N during digit 1's SHOW with an update pending → pins dark the same cycle. After release, upd_ready_o=1 and display=0000.
